// File: rtl/wave_loader.sv
// Waveform RAM writer: streams one full table of samples into consecutive RAM
// addresses, holds the read side while loading, and keeps a running checksum.
module wave_loader #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            abort,
   input  logic                            in_valid,
   input  logic [DATA_WIDTH-1:0]           in_data,
   output logic                            in_ready,
   output logic                            wr_en,
   output logic [ADDRESS_WIDTH-1:0]        wr_addr,
   output logic [DATA_WIDTH-1:0]           wr_data,
   output logic                            busy,
   output logic                            done,
   output logic [DATA_WIDTH+ADDRESS_WIDTH-1:0] checksum
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST = {ADDRESS_WIDTH{1'b1}};
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]                            state_r;
   logic [ADDRESS_WIDTH-1:0]              addr_r;
   logic [DATA_WIDTH+ADDRESS_WIDTH-1:0]   checksum_r;
   logic                                  wr_en_r;
   logic [ADDRESS_WIDTH-1:0]              wr_addr_r;
   logic [DATA_WIDTH-1:0]                 wr_data_r;
   logic                                  ready_s;
   logic                                  accept_s;

   // Handshake: abort blocks acceptance in the same cycle so it always wins.
   always_comb begin
      ready_s  = 1'b0;
      accept_s = 1'b0;
      if (state_r == LOAD) begin
         ready_s  = !abort;
         accept_s = in_valid && !abort;
      end else begin
         ready_s  = 1'b0;
         accept_s = 1'b0;
      end
   end

   // Load sequencing, write strobe generation and checksum accumulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         addr_r     <= {ADDRESS_WIDTH{1'b0}};
         checksum_r <= {(DATA_WIDTH+ADDRESS_WIDTH){1'b0}};
         wr_en_r    <= 1'b0;
         wr_addr_r  <= {ADDRESS_WIDTH{1'b0}};
         wr_data_r  <= {DATA_WIDTH{1'b0}};
      end else begin
         wr_en_r <= 1'b0;
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  state_r    <= LOAD;
                  addr_r     <= {ADDRESS_WIDTH{1'b0}};
                  checksum_r <= {(DATA_WIDTH+ADDRESS_WIDTH){1'b0}};
               end
            end
            LOAD: begin
               if (abort) begin
                  // Partial checksum is kept visible until the next start.
                  state_r <= IDLE;
               end else if (accept_s) begin
                  wr_en_r    <= 1'b1;
                  wr_addr_r  <= addr_r;
                  wr_data_r  <= in_data;
                  checksum_r <= checksum_r + {{ADDRESS_WIDTH{1'b0}}, in_data};
                  addr_r     <= addr_r + ADDR_ONE;
                  if (addr_r == ADDR_LAST) begin
                     state_r <= DONE;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign in_ready = ready_s;
   assign wr_en    = wr_en_r;
   assign wr_addr  = wr_addr_r;
   assign wr_data  = wr_data_r;
   assign busy     = (state_r == LOAD);
   assign done     = (state_r == DONE);
   assign checksum = checksum_r;

endmodule

// File: tb/tb_wave_loader.sv
// Randomised bench for wave_loader: a queue-based load model predicts every
// output each cycle, with a few literal expectations pinning the model.
module tb_wave_loader;

   localparam int AW    = 8;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          done;
   logic [DW+AW-1:0] checksum;

   wave_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .checksum(checksum)
   );

   always #5 clk = ~clk;

   // Model: phase 0=idle 1=loading 2=complete; accepted samples kept in a queue.
   int      m_phase = 0;
   int      m_count = 0;
   int      m_samples[$];
   int      m_wr_en = 0;
   int      m_wr_addr = 0;
   int      m_wr_data = 0;
   int      passed = 0;
   int      total = 0;

   function automatic int model_sum();
      int s = 0;
      foreach (m_samples[i]) s += m_samples[i];
      return s;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      else
         passed++;
   endtask

   task automatic model_step();
      m_wr_en = 0;
      if (rst) begin
         m_phase = 0; m_count = 0; m_samples.delete();
         m_wr_addr = 0; m_wr_data = 0;
      end else if (m_phase == 1) begin
         if (abort) m_phase = 0;
         else if (in_valid) begin
            m_wr_en = 1;
            m_wr_addr = m_count % DEPTH;
            m_wr_data = in_data;
            m_samples.push_back(in_data);
            m_count++;
            if (m_count == DEPTH) m_phase = 2;
         end
      end else if (start) begin
         m_phase = 1; m_count = 0; m_samples.delete();
      end
   endtask

   // One clock: drive, check combinational ready, advance model, compare outputs.
   task automatic cyc(input logic r, input logic s, input logic a, input logic v, input logic [DW-1:0] d);
      rst = r; start = s; abort = a; in_valid = v; in_data = d;
      #1;
      check("in_ready", in_ready, (m_phase == 1 && !a) ? 1 : 0);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("wr_en", wr_en, m_wr_en);
      check("wr_addr", wr_addr, m_wr_addr);
      check("wr_data", wr_data, m_wr_data);
      check("busy", busy, (m_phase == 1) ? 1 : 0);
      check("done", done, (m_phase == 2) ? 1 : 0);
      check("checksum", checksum, model_sum());
   endtask

   initial begin
      // Bring the DUT out of X before any checking starts.
      @(posedge clk); model_step();
      @(posedge clk); model_step();
      @(negedge clk);

      // Reset held with start/in_valid asserted, then idle after release.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
      check("rst_wr_en", wr_en, 0);
      check("rst_checksum", checksum, 0);
      check("rst_busy", busy, 0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
      check("idle_busy_lit", busy, 0);

      // Full load with in_data = address.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("start_busy_lit", busy, 1);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, i[DW-1:0]);
      check("full_sum_lit", checksum, 32'h0000_7F80);
      check("full_done_lit", done, 1);
      check("full_last_addr_lit", wr_addr, 32'h0000_00FF);
      check("full_busy_lit", busy, 0);

      // Ignored samples in DONE.
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF);
      check("done_sum_lit", checksum, 32'h0000_7F80);

      // Backpressure 1,0,0 pattern with stray starts during the load.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h22);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C);
      check("gap_sum_lit", checksum, 32'h0000_00E1);
      check("gap_addr_lit", wr_addr, 32'h0000_0001);
      for (int i = 0; i < 3 * DEPTH && m_phase == 1; i++)
         cyc(1'b0, ($urandom_range(0, 7) == 0), 1'b0, (i % 3 == 0), $urandom_range(0, 255));
      check("gap_completed", m_phase, 2);

      // Abort after 100 accepts, with in_valid high at the same time.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, $urandom_range(0, 255));
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
      check("abort_wr_en_lit", wr_en, 0);
      check("abort_done_lit", done, 0);
      check("abort_busy_lit", busy, 0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("restart_sum_lit", checksum, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h42);
      check("restart_addr_lit", wr_addr, 0);
      check("restart_sum2_lit", checksum, 32'h0000_0042);

      // Reset mid-load after 50 accepts, then a fresh full random load.
      for (int i = 0; i < 49; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, $urandom_range(0, 255));
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
      check("midrst_wr_en_lit", wr_en, 0);
      check("midrst_sum_lit", checksum, 0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, $urandom_range(0, 255));
      check("reload_done", done, 1);

      // Random soup across all inputs.
      for (int i = 0; i < 4000; i++)
         cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
             $urandom_range(0, 255));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/wave_loader.md
# wave_loader

Writer side of the signal-generator waveform RAM. Accepts a stream of samples over a valid/ready handshake and writes them to consecutive RAM addresses 0 .. 2^ADDRESS_WIDTH-1, filling one complete waveform table per load. While a load is in progress, it asserts a hold to stop the read-side address counters. It reports completion and a running checksum of the loaded table.

## Interface
- ADDRESS_WIDTH, 8, RAM address width; table depth = 2^ADDRESS_WIDTH.
- DATA_WIDTH, 8, sample width.

- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset; highest priority.
- start  input  1  begin a load; sampled only in IDLE or DONE.
- abort  input  1  cancel a load; sampled only in LOAD.
- in_valid  input  1  sample present on in_data.
- in_data  input  DATA_WIDTH  sample value.
- in_ready  output  1  loader can accept; combinational = (state == LOAD) && !abort.
- wr_en  output  1  registered RAM write strobe.
- wr_addr  output  ADDRESS_WIDTH  registered RAM write address.
- wr_data  output  DATA_WIDTH  registered RAM write data.
- busy  output  1  high in LOAD; read-side counters treat it as a hold (their enable is gated low).
- done  output  1  high in DONE.
- checksum  output  DATA_WIDTH+ADDRESS_WIDTH  unsigned sum of samples accepted in the current or last load.

## Operation
- States: IDLE, LOAD, DONE. Reset state is IDLE.
- IDLE: start=1 -> LOAD. Entry into LOAD clears the address counter and checksum to 0.
- LOAD:
  - Accept occurs when in_valid && in_ready.
  - On each accept: write in_data at the current address, add in_data (zero-extended) to checksum, and increment the address.
  - When the accepted sample is at address 2^ADDRESS_WIDTH-1: transition to DONE; the address wraps to 0.
  - abort=1 -> IDLE. No accept occurs in that cycle. Checksum keeps its partial value until the next start.
  - start is ignored in LOAD.
- DONE:
  - start=1 -> LOAD. Address and checksum are cleared as on entry from IDLE.
  - abort is ignored in DONE.
- in_valid is ignored outside LOAD (in_ready=0). No writes and no checksum change.
- Checksum width DATA_WIDTH+ADDRESS_WIDTH cannot overflow for one full table.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, checksum=0, in_ready=0.

## Timing
- start sampled at edge E: busy=1 and in_ready=1 from cycle E+1. The first accept can occur at edge E+1.
- Write latency is 1 cycle. For an accept at edge k, wr_en=1 with the matching wr_addr/wr_data during cycle k+1 (i.e. after edge k). wr_en is otherwise 0.
- wr_addr/wr_data hold their last values when wr_en=0.
- checksum includes the sample accepted at edge k from cycle k+1.
- Last accept at edge L: from cycle L+1, done=1, busy=0, and in_ready=0. The final wr_en is also in cycle L+1, so done coincides with the last write.
- Throughput: one sample per cycle with in_valid held high. A full table takes 2^ADDRESS_WIDTH accept cycles.
- Simultaneous in_valid and abort in LOAD: abort wins. No write occurs; the next state is IDLE.
- rst=1 at any edge, including mid-load: all outputs take their reset values after that edge. A write already pending from the previous accept is dropped (wr_en=0).

## Test plan
- Reset: hold rst for 3 cycles with in_valid=1 and start=1 -> all outputs 0, in_ready=0; after release with start=0, the block remains IDLE.
- Full load (defaults): pulse start, then in_valid=1 with in_data=address for 256 cycles -> wr_en high 256 consecutive cycles, wr_addr 0..255, wr_data=wr_addr. done rises in the cycle of the final write; checksum=0x7F80; busy low afterwards.
- Backpressure gaps: toggle in_valid 1,0,0,1,... with data 0xA5, 0x3C, ... -> wr_addr advances only on accepts, wr_en only one cycle after each accept, and checksum equals the sum of accepted samples only.
- Ignored inputs: in_valid=1 with data 0xFF in IDLE and in DONE, and start=1 during LOAD -> no wr_en, checksum unchanged, and the load continues without an address reset.
- Abort: after 100 accepts assert abort together with in_valid -> no write for that sample, state IDLE, done=0. A following start restarts at wr_addr=0 with checksum cleared.
- Reset mid-load: assert rst after 50 accepts -> outputs 0 next cycle; a new start then loads from address 0.
